// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the frame slot scheduler: the per-slot
// ownership state, the slot index width and the slot address calculation.
package frame_buffer_pkg;

    // Three index bits cover the largest supported ring of eight slots.
    localparam int SLOT_IDX_W = 3;
    localparam int SLOT_MAX   = 1 << SLOT_IDX_W;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } slot_state_t;

    // Byte base address of a slot; the sum wraps modulo 2^32.
    function automatic logic [31:0] slot_addr(
        input logic [31:0]           base,
        input logic [31:0]           stride,
        input logic [SLOT_IDX_W-1:0] idx
    );
        return base + stride * {{(32 - SLOT_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/frame_slot_sched_if.sv
// Handshake bundle between the frame writer/reader and the slot scheduler.
// The master side (writer and reader) drives requests and done pulses.
// The slave side (scheduler) returns grants, slot addresses and statistics.
interface frame_slot_sched_if;

    logic        wr_req_i;
    logic        wr_grant_o;
    logic [31:0] wr_addr_o;
    logic        wr_done_i;

    logic        rd_req_i;
    logic        rd_grant_o;
    logic [31:0] rd_addr_o;
    logic        rd_done_i;

    logic [15:0] dropped_o;
    logic [15:0] repeated_o;

    modport master (
        output wr_req_i, wr_done_i, rd_req_i, rd_done_i,
        input  wr_grant_o, wr_addr_o, rd_grant_o, rd_addr_o,
        input  dropped_o, repeated_o
    );

    modport slave (
        input  wr_req_i, wr_done_i, rd_req_i, rd_done_i,
        output wr_grant_o, wr_addr_o, rd_grant_o, rd_addr_o,
        output dropped_o, repeated_o
    );

endinterface

// File: rtl/frame_slot_pick.sv
// Combinational priority encoder that returns the lowest-index set bit
// of the free-slot mask, plus a flag saying whether any slot is free.
module frame_slot_pick
    import frame_buffer_pkg::*;
(
    input  logic [SLOT_MAX-1:0]   free_mask,
    output logic [SLOT_IDX_W-1:0] pick_idx,
    output logic                  pick_found
);

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = SLOT_MAX - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                pick_idx   = SLOT_IDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_slot_sched.sv
// Frame slot scheduler: hands out frame buffer slots to one writer and one
// reader so the reader always gets the newest completed frame and the
// writer never overwrites a frame being displayed.
// Optional feature: define FRAME_SLOT_SCHED_STATS_EN to build the dropped
// and repeated frame counters; without it both outputs are tied to zero.
module frame_slot_sched
    import frame_buffer_pkg::*;
#(
    parameter logic [31:0] START_ADDR    = 32'h0000_0000,
    parameter int          FRAMES_AMOUNT = 3,
    parameter logic [31:0] FRAME_BYTES   = 32'(1920 * 1080 * 2)
)(
    input logic               clk_i,
    input logic               rst_n_i,
    frame_slot_sched_if.slave bus
);

    // Slots at or above FRAMES_AMOUNT are held FREE and masked from selection.
    slot_state_t slot_q [SLOT_MAX];
    slot_state_t slot_d [SLOT_MAX];

    logic                  wr_active_q, wr_active_d;
    logic [SLOT_IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic                  ready_valid_q, ready_valid_d;
    logic [SLOT_IDX_W-1:0] ready_idx_q, ready_idx_d;
    logic                  rd_held_q, rd_held_d;
    logic [SLOT_IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic                  frame_avail_q, frame_avail_d;
    logic                  wr_grant_q, wr_grant_d;
    logic                  rd_grant_q, rd_grant_d;
    logic [31:0]           wr_addr_q, wr_addr_d;
    logic [31:0]           rd_addr_q, rd_addr_d;
    logic                  wr_done_ok;
    logic [SLOT_MAX-1:0]   free_mask;
    logic [SLOT_IDX_W-1:0] pick_idx;
    logic                  pick_found;
`ifdef FRAME_SLOT_SCHED_STATS_EN
    logic                  drop_inc;
    logic                  rep_inc;
    logic [15:0]           dropped_q;
    logic [15:0]           repeated_q;
`endif

    // Mark which in-range slots are currently free for the writer.
    always_comb begin
        free_mask = '0;
        for (int i = 0; i < SLOT_MAX; i++) begin
            free_mask[i] = (i < FRAMES_AMOUNT) && (slot_q[i] == FREE);
        end
    end

    frame_slot_pick u_pick (
        .free_mask  (free_mask),
        .pick_idx   (pick_idx),
        .pick_found (pick_found)
    );

    // Next-state: retire the written frame, then serve the reader, then the writer.
    always_comb begin
        slot_d        = slot_q;
        wr_active_d   = wr_active_q;
        wr_idx_d      = wr_idx_q;
        ready_valid_d = ready_valid_q;
        ready_idx_d   = ready_idx_q;
        rd_held_d     = rd_held_q;
        rd_idx_d      = rd_idx_q;
        frame_avail_d = frame_avail_q;
        wr_grant_d    = 1'b0;
        rd_grant_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
`ifdef FRAME_SLOT_SCHED_STATS_EN
        drop_inc      = 1'b0;
        rep_inc       = 1'b0;
`endif
        wr_done_ok    = bus.wr_done_i && wr_active_q;

        if (wr_done_ok) begin
            if (ready_valid_q) begin
                slot_d[ready_idx_q] = FREE;
`ifdef FRAME_SLOT_SCHED_STATS_EN
                drop_inc = 1'b1;
`endif
            end
            slot_d[wr_idx_q] = READY;
            ready_valid_d    = 1'b1;
            ready_idx_d      = wr_idx_q;
            wr_active_d      = 1'b0;
            frame_avail_d    = 1'b1;
        end

        if (bus.rd_req_i && (frame_avail_q || wr_done_ok)) begin
            rd_grant_d = 1'b1;
            if (ready_valid_d) begin
                if (rd_held_q) begin
                    slot_d[rd_idx_q] = FREE;
                end
                slot_d[ready_idx_d] = READING;
                rd_held_d     = 1'b1;
                rd_idx_d      = ready_idx_d;
                ready_valid_d = 1'b0;
                rd_addr_d     = slot_addr(START_ADDR, FRAME_BYTES, ready_idx_d);
            end else begin
`ifdef FRAME_SLOT_SCHED_STATS_EN
                rep_inc = 1'b1;
`endif
                rd_addr_d = slot_addr(START_ADDR, FRAME_BYTES, rd_idx_q);
            end
        end

        if (bus.wr_req_i && !wr_active_q && pick_found) begin
            slot_d[pick_idx] = WRITING;
            wr_active_d      = 1'b1;
            wr_idx_d         = pick_idx;
            wr_grant_d       = 1'b1;
            wr_addr_d        = slot_addr(START_ADDR, FRAME_BYTES, pick_idx);
        end
    end

    // State register; reset drops every ownership and any pending grant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SLOT_MAX; i++) begin
                slot_q[i] <= FREE;
            end
            wr_active_q   <= 1'b0;
            wr_idx_q      <= '0;
            ready_valid_q <= 1'b0;
            ready_idx_q   <= '0;
            rd_held_q     <= 1'b0;
            rd_idx_q      <= '0;
            frame_avail_q <= 1'b0;
            wr_grant_q    <= 1'b0;
            rd_grant_q    <= 1'b0;
            wr_addr_q     <= START_ADDR;
            rd_addr_q     <= START_ADDR;
        end else begin
            slot_q        <= slot_d;
            wr_active_q   <= wr_active_d;
            wr_idx_q      <= wr_idx_d;
            ready_valid_q <= ready_valid_d;
            ready_idx_q   <= ready_idx_d;
            rd_held_q     <= rd_held_d;
            rd_idx_q      <= rd_idx_d;
            frame_avail_q <= frame_avail_d;
            wr_grant_q    <= wr_grant_d;
            rd_grant_q    <= rd_grant_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign bus.wr_grant_o = wr_grant_q;
    assign bus.rd_grant_o = rd_grant_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.rd_addr_o  = rd_addr_q;

`ifdef FRAME_SLOT_SCHED_STATS_EN
    // Saturating counters for frames dropped unread and frames shown twice.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dropped_q  <= '0;
            repeated_q <= '0;
        end else begin
            if (drop_inc && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            if (rep_inc && (repeated_q != 16'hFFFF)) begin
                repeated_q <= repeated_q + 16'd1;
            end
        end
    end

    assign bus.dropped_o  = dropped_q;
    assign bus.repeated_o = repeated_q;
`else
    assign bus.dropped_o  = '0;
    assign bus.repeated_o = '0;
`endif

endmodule

// File: tb/tb_frame_slot_sched.sv
// Self-checking bench for frame_slot_sched: directed scenarios followed by
// randomized writer/reader traffic, all compared against a role-based
// reference model (which slot the writer, the newest frame and the reader
// own) rather than a per-slot state machine.
module tb_frame_slot_sched;

    localparam logic [31:0] SA    = 32'h1000_0000;
    localparam logic [31:0] FB    = 32'h0040_0000;
    localparam int          NSLOT = 3;
`ifdef FRAME_SLOT_SCHED_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int          m_writer;
    int          m_ready;
    int          m_reader;
    bit          m_seen;
    logic [31:0] m_wr_addr;
    logic [31:0] m_rd_addr;
    int          m_drop;
    int          m_rep;
    bit          m_wg;
    bit          m_rg;
    bit          wr_pend;
    bit          rd_pend;

    frame_slot_sched_if bus();

    frame_slot_sched #(
        .START_ADDR    (SA),
        .FRAMES_AMOUNT (NSLOT),
        .FRAME_BYTES   (FB)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] addrOf(input int idx);
        return SA + FB * 32'(idx);
    endfunction

    function automatic logic [31:0] expCnt(input int c);
        return STATS_EN ? 32'(c) : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    task automatic modelReset();
        m_writer  = -1;
        m_ready   = -1;
        m_reader  = -1;
        m_seen    = 1'b0;
        m_wr_addr = SA;
        m_rd_addr = SA;
        m_drop    = 0;
        m_rep     = 0;
        m_wg      = 1'b0;
        m_rg      = 1'b0;
        wr_pend   = 1'b0;
        rd_pend   = 1'b0;
    endtask

    // One clock edge of the reference: roles change hands, grants are decided.
    task automatic modelStep(input logic wreq, input logic wdone, input logic rreq);
        int  pick;
        bit  grant_w;
        pick = -1;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (i != m_writer && i != m_ready && i != m_reader) pick = i;
        end
        grant_w = wreq && (m_writer < 0) && (pick >= 0);
        m_wg = 1'b0;
        m_rg = 1'b0;
        if (wdone && m_writer >= 0) begin
            if (m_ready >= 0 && m_drop < 65535) m_drop++;
            m_ready  = m_writer;
            m_writer = -1;
            m_seen   = 1'b1;
        end
        if (rreq && m_seen) begin
            m_rg = 1'b1;
            if (m_ready >= 0) begin
                m_reader = m_ready;
                m_ready  = -1;
            end else if (m_rep < 65535) begin
                m_rep++;
            end
            m_rd_addr = addrOf(m_reader);
        end
        if (grant_w) begin
            m_writer  = pick;
            m_wg      = 1'b1;
            m_wr_addr = addrOf(pick);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic wreq, input logic wdone, input logic rreq, input logic rdone);
        @(negedge clk);
        bus.wr_req_i  = wreq;
        bus.wr_done_i = wdone;
        bus.rd_req_i  = rreq;
        bus.rd_done_i = rdone;
        modelStep(wreq, wdone, rreq);
        @(posedge clk);
        #1;
        checkOutput("wr_grant", 32'(bus.wr_grant_o), 32'(m_wg));
        checkOutput("rd_grant", 32'(bus.rd_grant_o), 32'(m_rg));
        checkOutput("wr_addr",  bus.wr_addr_o, m_wr_addr);
        checkOutput("rd_addr",  bus.rd_addr_o, m_rd_addr);
        checkOutput("dropped",  32'(bus.dropped_o),  expCnt(m_drop));
        checkOutput("repeated", 32'(bus.repeated_o), expCnt(m_rep));
    endtask

    // Assert reset right now (possibly between edges) and check it bites at once.
    task automatic doReset();
        bus.wr_req_i  = 1'b0;
        bus.wr_done_i = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.rd_done_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wr_grant", 32'(bus.wr_grant_o), 32'd0);
        checkOutput("rst_rd_grant", 32'(bus.rd_grant_o), 32'd0);
        checkOutput("rst_wr_addr",  bus.wr_addr_o, SA);
        checkOutput("rst_rd_addr",  bus.rd_addr_o, SA);
        checkOutput("rst_dropped",  32'(bus.dropped_o), 32'd0);
        checkOutput("rst_repeated", 32'(bus.repeated_o), 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.wr_req_i  = 1'b0;
        bus.wr_done_i = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.rd_done_i = 1'b0;
        modelReset();
        #2;
        doReset();

        // First write grant, reads blocked until a frame completes.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("first_wr_grant", 32'(bus.wr_grant_o), 32'd1);
        checkOutput("first_wr_addr", bus.wr_addr_o, SA);
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("rd_before_frame", 32'(bus.rd_grant_o), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rd_after_done", 32'(bus.rd_grant_o), 32'd1);
        checkOutput("rd_first_addr", bus.rd_addr_o, SA);

        // Second read with no new frame reissues the same slot.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("repeat_addr", bus.rd_addr_o, SA);
        checkOutput("repeat_count", 32'(bus.repeated_o), expCnt(1));

        // Done and read together pick the fresh frame and free slot 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_slot1_addr", bus.wr_addr_o, SA + FB);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rd_same_cycle", bus.rd_addr_o, SA + FB);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("slot0_freed", bus.wr_addr_o, SA);

        // Two frames completed without a read: one dropped, slot 0 reused.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_wr_slot1", bus.wr_addr_o, SA + FB);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_count", 32'(bus.dropped_o), expCnt(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_reuse_addr", bus.wr_addr_o, SA);

        // Simultaneous write and read requests grant distinct slots together.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("both_wr_grant", 32'(bus.wr_grant_o), 32'd1);
        checkOutput("both_rd_grant", 32'(bus.rd_grant_o), 32'd1);
        checkOutput("both_rd_addr", bus.rd_addr_o, SA);
        checkOutput("both_wr_addr", bus.wr_addr_o, SA + FB);

        // Reset between edges while grants are high, then start over at slot 0.
        #2;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_wr_addr", bus.wr_addr_o, SA);

        // Randomized writer/reader traffic, including stray done pulses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic wreq;
            logic wdone;
            logic rreq;
            logic rdone;
            if (!wr_pend && m_writer < 0 && $urandom_range(2) == 0) wr_pend = 1'b1;
            if (!rd_pend && $urandom_range(2) == 0) rd_pend = 1'b1;
            wreq  = wr_pend || (m_writer >= 0 && $urandom_range(7) == 0);
            wdone = (m_writer >= 0) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            rreq  = rd_pend;
            rdone = ($urandom_range(4) == 0);
            applyStimulus(wreq, wdone, rreq, rdone);
            if (m_wg) wr_pend = 1'b0;
            if (m_rg) rd_pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_slot_sched.md
FRAME_SLOT_SCHED -- requirements
Module: frame_slot_sched

Interface
REQ-001 Parameter START_ADDR, default 0: byte base address of slot 0 in memory.
REQ-002 Parameter FRAMES_AMOUNT, default 3: number of frame slots; legal range 3..8.
REQ-003 Parameter FRAME_BYTES, default 1920*1080*2: byte stride between slots.
REQ-004 Port clk_i  input  1: single clock; every port is synchronous to it.
REQ-005 Port rst_n_i  input  1: reset, asynchronous and active-low.
REQ-006 Port wr_req_i  input  1: the writer requests a slot for a new frame; held until granted.
REQ-007 Port wr_grant_o  output  1: one-cycle pulse; a slot is assigned to the writer.
REQ-008 Port wr_addr_o  output  32: base address of the granted write slot; valid from grant until the next grant.
REQ-009 Port wr_done_i  input  1: one-cycle pulse; the current write frame is complete (last B response received).
REQ-010 Port rd_req_i  input  1: the reader requests a frame to display; held until granted.
REQ-011 Port rd_grant_o  output  1: one-cycle pulse; a slot is assigned to the reader.
REQ-012 Port rd_addr_o  output  32: base address of the granted read slot.
REQ-013 Port rd_done_i  input  1: one-cycle pulse; the reader has finished its current slot.
REQ-014 Port dropped_o  output  16: count of completed frames freed without ever being read.
REQ-015 Port repeated_o  output  16: count of read grants that reissued an already-read slot.

Function
REQ-016 Each slot SHALL hold exactly one state: FREE, WRITING, READY or READING.
REQ-017 A write grant SHALL pulse exactly 1 cycle after wr_req_i is sampled high while the writer holds no slot.
  - Chosen slot: lowest-index FREE slot.
  - That slot moves to WRITING.
REQ-018 wr_req_i while a slot is WRITING SHALL be ignored until wr_done_i.
REQ-019 On wr_done_i, the WRITING slot SHALL become READY and be recorded as newest.
  - Any older READY slot becomes FREE, and dropped_o increments.
REQ-020 A read grant SHALL pulse 1 cycle after rd_req_i is sampled high, selecting in this order:
  - the newest READY slot, which becomes READING, and the reader's previous slot becomes FREE; otherwise
  - the reader's current/last slot, reissued, and repeated_o increments.
REQ-021 Before the first wr_done_i after reset, rd_req_i SHALL NOT be granted; the grant waits for that done.
REQ-022 On rd_done_i, the READING slot SHALL remain reserved for repeat until a newer READY slot is granted.
REQ-023 If wr_done_i and rd_req_i are sampled in the same cycle, the read grant SHALL select the just-completed slot.
REQ-024 If wr_req_i and rd_req_i are sampled in the same cycle, both grants SHALL issue in the same cycle, on distinct slots.
REQ-025 Slot address SHALL be START_ADDR + index*FRAME_BYTES, truncated to 32 bits (wraps modulo 2^32).
REQ-026 Both counters SHALL saturate at 0xFFFF.
REQ-027 wr_done_i with no WRITING slot, and rd_done_i with no READING slot, SHALL be ignored.

Reset
REQ-028 While rst_n_i is low, the following SHALL be forced immediately, independent of clk_i:
  - all slots FREE;
  - wr_grant_o and rd_grant_o = 0;
  - wr_addr_o and rd_addr_o = START_ADDR;
  - counters = 0;
  - the "frame available" flag cleared.
REQ-029 Reset asserted mid-frame SHALL abandon all slot ownership; no pending grant survives it.

Configuration
REQ-030 Macro FRAME_SLOT_SCHED_STATS_EN defined: dropped_o and repeated_o SHALL count as specified.
REQ-031 Macro FRAME_SLOT_SCHED_STATS_EN undefined: counter logic SHALL be absent and both outputs SHALL be constant 0.

Structure
REQ-032 frame_buffer_pkg SHALL hold:
  - slot_state_t (FREE/WRITING/READY/READING);
  - the slot-index width constant;
  - the slot-address function.
REQ-033 Lowest-FREE selection SHALL live in sub-module frame_slot_pick (a combinational priority encoder); everything else stays in frame_slot_sched.

Verification
Bench parameters: START_ADDR=0x1000_0000, FRAME_BYTES=0x0040_0000, FRAMES_AMOUNT=3.
REQ-034 Reset, then wr_req_i high -> wr_grant_o pulses next cycle, wr_addr_o=0x1000_0000.
REQ-035 rd_req_i held with no frame written -> no rd_grant_o; wr_done_i on slot 0 in cycle N -> rd_grant_o in N+1, rd_addr_o=0x1000_0000.
REQ-036 Write slot 0 done, write slot 1 done with no read in between -> dropped_o=1; next wr grant gives 0x1000_0000.
REQ-037 Two rd_req_i with no new wr_done_i between them -> second rd_addr_o equals the first, repeated_o=1.
REQ-038 wr_done_i and rd_req_i in the same cycle, while the reader holds slot 0 and slot 1 is writing -> rd_addr_o=0x1040_0000; slot 0 freed.
REQ-039 rst_n_i driven low mid-frame, between clock edges -> grants and counters are 0 before the next clk_i edge; the next wr_req_i receives slot 0.
